// File: rtl/alu_pkg.sv
// Shared definitions for the pipelined integer execution unit:
// opcode encoding, opcode width and a branch-classification helper.
package alu_pkg;

  localparam int OP_W = 5;

  // Register/immediate arithmetic (bit 4 clear)
  localparam logic [OP_W-1:0] OP_ADD  = 5'd0;
  localparam logic [OP_W-1:0] OP_SUB  = 5'd1;
  localparam logic [OP_W-1:0] OP_SLL  = 5'd2;
  localparam logic [OP_W-1:0] OP_SLT  = 5'd3;
  localparam logic [OP_W-1:0] OP_SLTU = 5'd4;
  localparam logic [OP_W-1:0] OP_XOR  = 5'd5;
  localparam logic [OP_W-1:0] OP_SRL  = 5'd6;
  localparam logic [OP_W-1:0] OP_SRA  = 5'd7;
  localparam logic [OP_W-1:0] OP_OR   = 5'd8;
  localparam logic [OP_W-1:0] OP_AND  = 5'd9;

  // Conditional branches (bit 4 set)
  localparam logic [OP_W-1:0] OP_BEQ  = 5'd16;
  localparam logic [OP_W-1:0] OP_BNE  = 5'd17;
  localparam logic [OP_W-1:0] OP_BLT  = 5'd18;
  localparam logic [OP_W-1:0] OP_BGE  = 5'd19;
  localparam logic [OP_W-1:0] OP_BLTU = 5'd20;
  localparam logic [OP_W-1:0] OP_BGEU = 5'd21;

  // Only the six defined branch codes count as branches; other codes with
  // bit 4 set are undefined and behave like a non-branch producing zero.
  function automatic logic is_branch(input logic [OP_W-1:0] op);
    logic res;
    case (op)
      OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: res = 1'b1;
      default:                                         res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational datapath: evaluates one ALU or branch op from
// already-registered operands.
module alu_core
  import alu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [XLEN-1:0] pc,
  input  logic [XLEN-1:0] imm,
  output logic [XLEN-1:0] value,
  output logic            taken,
  output logic            branch,
  output logic [XLEN-1:0] target
);

  localparam int SHW = $clog2(XLEN);

  logic [SHW-1:0] shamt_s;
  logic           lt_signed_s;
  logic           lt_unsigned_s;

  assign shamt_s       = b[SHW-1:0];
  assign lt_signed_s   = ($signed(a) < $signed(b));
  assign lt_unsigned_s = (a < b);

  // Operation decode; branches report 0/1 on value and a target, all
  // other ops leave taken/target at zero.
  always_comb begin
    value  = {XLEN{1'b0}};
    taken  = 1'b0;
    target = {XLEN{1'b0}};
    branch = is_branch(op);
    case (op)
      OP_ADD:  value = a + b;
      OP_SUB:  value = a - b;
      OP_SLL:  value = a << shamt_s;
      OP_SLT:  value = {{(XLEN-1){1'b0}}, lt_signed_s};
      OP_SLTU: value = {{(XLEN-1){1'b0}}, lt_unsigned_s};
      OP_XOR:  value = a ^ b;
      OP_SRL:  value = a >> shamt_s;
      OP_SRA:  value = $unsigned($signed(a) >>> shamt_s);
      OP_OR:   value = a | b;
      OP_AND:  value = a & b;
      OP_BEQ:  taken = (a == b);
      OP_BNE:  taken = (a != b);
      OP_BLT:  taken = lt_signed_s;
      OP_BGE:  taken = !lt_signed_s;
      OP_BLTU: taken = lt_unsigned_s;
      OP_BGEU: taken = !lt_unsigned_s;
      default: value = {XLEN{1'b0}};
    endcase
    if (branch) begin
      value  = {{(XLEN-1){1'b0}}, taken};
      target = pc + imm;
    end else begin
      target = {XLEN{1'b0}};
    end
  end

endmodule

// File: rtl/alu_pipe.sv
// Pipelined integer execution unit: optional operand register stage,
// combinational ALU, result register, valid/ready backpressure, global
// freeze (rdy_in) and mispredict flush.
module alu_pipe
  import alu_pkg::*;
#(
  parameter int XLEN   = 32,
  parameter int TAG_W  = 4,
  parameter int STAGES = 2
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [OP_W-1:0]  in_op,
  input  logic [XLEN-1:0]  in_a,
  input  logic [XLEN-1:0]  in_b,
  input  logic [XLEN-1:0]  in_pc,
  input  logic [XLEN-1:0]  in_imm,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [TAG_W-1:0] out_tag,
  output logic [XLEN-1:0]  out_value,
  output logic             out_is_branch,
  output logic             out_taken,
  output logic [XLEN-1:0]  out_target
);

  // Result (final) stage registers
  logic             out_valid_r;
  logic [TAG_W-1:0] out_tag_r;
  logic [XLEN-1:0]  out_value_r;
  logic             out_is_branch_r;
  logic             out_taken_r;
  logic [XLEN-1:0]  out_target_r;

  // Operands feeding the final stage (registered or straight from input)
  logic             feed_valid_s;
  logic [OP_W-1:0]  feed_op_s;
  logic [XLEN-1:0]  feed_a_s;
  logic [XLEN-1:0]  feed_b_s;
  logic [XLEN-1:0]  feed_pc_s;
  logic [XLEN-1:0]  feed_imm_s;
  logic [TAG_W-1:0] feed_tag_s;

  logic             out_stage_ready_s;
  logic             ready0_s;
  logic             in_ready_s;
  logic             in_accept_s;

  logic [XLEN-1:0]  core_value_s;
  logic             core_taken_s;
  logic             core_branch_s;
  logic [XLEN-1:0]  core_target_s;

  assign out_stage_ready_s = !out_valid_r || out_ready;
  assign in_ready_s        = ready0_s && rdy_in && !flush_in;
  assign in_accept_s       = in_valid && in_ready_s;
  assign in_ready          = in_ready_s;

  generate
    if (STAGES == 2) begin : g_two_stage
      logic             s0_valid_r;
      logic [OP_W-1:0]  s0_op_r;
      logic [XLEN-1:0]  s0_a_r;
      logic [XLEN-1:0]  s0_b_r;
      logic [XLEN-1:0]  s0_pc_r;
      logic [XLEN-1:0]  s0_imm_r;
      logic [TAG_W-1:0] s0_tag_r;

      assign ready0_s     = !s0_valid_r || out_stage_ready_s;
      assign feed_valid_s = s0_valid_r;
      assign feed_op_s    = s0_op_r;
      assign feed_a_s     = s0_a_r;
      assign feed_b_s     = s0_b_r;
      assign feed_pc_s    = s0_pc_r;
      assign feed_imm_s   = s0_imm_r;
      assign feed_tag_s   = s0_tag_r;

      // Operand register: captures the raw issue fields on acceptance
      always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
          s0_valid_r <= 1'b0;
          s0_op_r    <= {OP_W{1'b0}};
          s0_a_r     <= {XLEN{1'b0}};
          s0_b_r     <= {XLEN{1'b0}};
          s0_pc_r    <= {XLEN{1'b0}};
          s0_imm_r   <= {XLEN{1'b0}};
          s0_tag_r   <= {TAG_W{1'b0}};
        end else if (rdy_in) begin
          if (flush_in) begin
            s0_valid_r <= 1'b0;
          end else if (ready0_s) begin
            s0_valid_r <= in_accept_s;
            if (in_accept_s) begin
              s0_op_r  <= in_op;
              s0_a_r   <= in_a;
              s0_b_r   <= in_b;
              s0_pc_r  <= in_pc;
              s0_imm_r <= in_imm;
              s0_tag_r <= in_tag;
            end
          end
        end
      end
    end else begin : g_one_stage
      assign ready0_s     = out_stage_ready_s;
      assign feed_valid_s = in_accept_s;
      assign feed_op_s    = in_op;
      assign feed_a_s     = in_a;
      assign feed_b_s     = in_b;
      assign feed_pc_s    = in_pc;
      assign feed_imm_s   = in_imm;
      assign feed_tag_s   = in_tag;
    end
  endgenerate

  alu_core #(
    .XLEN (XLEN)
  ) u_core (
    .op     (feed_op_s),
    .a      (feed_a_s),
    .b      (feed_b_s),
    .pc     (feed_pc_s),
    .imm    (feed_imm_s),
    .value  (core_value_s),
    .taken  (core_taken_s),
    .branch (core_branch_s),
    .target (core_target_s)
  );

  // Result register: loads the computed result when the final stage advances
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      out_valid_r     <= 1'b0;
      out_tag_r       <= {TAG_W{1'b0}};
      out_value_r     <= {XLEN{1'b0}};
      out_is_branch_r <= 1'b0;
      out_taken_r     <= 1'b0;
      out_target_r    <= {XLEN{1'b0}};
    end else if (rdy_in) begin
      if (flush_in) begin
        out_valid_r <= 1'b0;
      end else if (out_stage_ready_s) begin
        out_valid_r <= feed_valid_s;
        if (feed_valid_s) begin
          out_tag_r       <= feed_tag_s;
          out_value_r     <= core_value_s;
          out_is_branch_r <= core_branch_s;
          out_taken_r     <= core_taken_s;
          out_target_r    <= core_target_s;
        end
      end
    end
  end

  assign out_valid     = out_valid_r;
  assign out_tag       = out_tag_r;
  assign out_value     = out_value_r;
  assign out_is_branch = out_is_branch_r;
  assign out_taken     = out_taken_r;
  assign out_target    = out_target_r;

endmodule

// File: tb/tb_alu_pipe.sv
// Scoreboard bench for alu_pipe (XLEN=32, TAG_W=4, STAGES=2): directed
// vectors push hand-computed results; a negedge monitor pops and compares.
module tb_alu_pipe;
  import alu_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b0;
  logic        rdy_in = 1'b1;
  logic        flush_in = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [4:0]  in_op = 5'd0;
  logic [31:0] in_a = 32'd0;
  logic [31:0] in_b = 32'd0;
  logic [31:0] in_pc = 32'd0;
  logic [31:0] in_imm = 32'd0;
  logic [3:0]  in_tag = 4'd0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [3:0]  out_tag;
  logic [31:0] out_value;
  logic        out_is_branch;
  logic        out_taken;
  logic [31:0] out_target;

  typedef struct {
    logic [3:0]  tag;
    logic [31:0] value;
    logic        br;
    logic        taken;
    logic [31:0] target;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  int   accept_cnt = 0;

  alu_pipe #(.XLEN(32), .TAG_W(4), .STAGES(2)) dut (
    .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in), .flush_in(flush_in),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a),
    .in_b(in_b), .in_pc(in_pc), .in_imm(in_imm), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .out_tag(out_tag),
    .out_value(out_value), .out_is_branch(out_is_branch),
    .out_taken(out_taken), .out_target(out_target)
  );

  always #5 clk_in = ~clk_in;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: a result is consumed when valid & ready & rdy_in and no flush.
  always @(negedge clk_in) begin
    if (rst_in && out_valid && out_ready && rdy_in && !flush_in) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_output", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("out_tag", {28'd0, out_tag}, {28'd0, e.tag});
        chk("out_value", out_value, e.value);
        chk("out_is_branch", {31'd0, out_is_branch}, {31'd0, e.br});
        chk("out_taken", {31'd0, out_taken}, {31'd0, e.taken});
        chk("out_target", out_target, e.target);
      end
    end
  end

  // Issue one op and push its expected result once the DUT accepts it.
  task automatic send(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc, input logic [31:0] imm, input logic [3:0] tag,
                      input logic [31:0] ev, input logic eb, input logic et,
                      input logic [31:0] etg);
    exp_t e;
    int   waited;
    in_valid = 1'b1; in_op = op; in_a = a; in_b = b;
    in_pc = pc; in_imm = imm; in_tag = tag;
    waited = 0;
    while (1) begin
      @(negedge clk_in);
      if (in_ready) begin
        e.tag = tag; e.value = ev; e.br = eb; e.taken = et; e.target = etg;
        exp_q.push_back(e);
        accept_cnt++;
        @(posedge clk_in); #1;
        break;
      end
      @(posedge clk_in); #1;
      waited++;
      if (waited > 50) begin
        chk("accept_timeout", 32'd1, 32'd0);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic send_add(input logic [31:0] a, input logic [31:0] b, input logic [3:0] tag);
    send(OP_ADD, a, b, 32'd0, 32'd0, tag, a + b, 1'b0, 1'b0, 32'd0);
  endtask

  task automatic drain;
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 100) begin
      @(posedge clk_in); #1;
      n++;
    end
    chk("drain_left", exp_q.size(), 32'd0);
  endtask

  logic [31:0] snap_value;
  logic [3:0]  snap_tag;
  logic        snap_valid;

  initial begin
    // Reset state
    #2;
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_out_tag", {28'd0, out_tag}, 32'd0);
    chk("rst_out_value", out_value, 32'd0);
    chk("rst_out_target", out_target, 32'd0);
    chk("rst_out_is_branch", {31'd0, out_is_branch}, 32'd0);
    chk("rst_out_taken", {31'd0, out_taken}, 32'd0);
    #10 rst_in = 1'b1;
    @(posedge clk_in); #1;
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);

    // ADD overflow wrap with explicit two-cycle latency check
    send(OP_ADD, 32'h7FFF_FFFF, 32'd1, 32'd0, 32'd0, 4'd3, 32'h8000_0000, 1'b0, 1'b0, 32'd0);
    @(negedge clk_in);
    chk("lat_cycle1_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk_in);
    chk("lat_cycle2_valid", {31'd0, out_valid}, 32'd1);
    @(posedge clk_in); #1;

    // Directed op vectors
    send(OP_SRA,  32'h8000_0000, 32'h21, 32'd0, 32'd0, 4'd1, 32'hC000_0000, 1'b0, 1'b0, 32'd0);
    send(OP_SLTU, 32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd2, 32'd1, 1'b0, 1'b0, 32'd0);
    send(OP_SLT,  32'd1, 32'hFFFF_FFFF, 32'd0, 32'd0, 4'd3, 32'd0, 1'b0, 1'b0, 32'd0);
    send(OP_BLT,  32'hFFFF_FFFF, 32'd0, 32'h100, 32'hFFFF_FFF0, 4'd4, 32'd1, 1'b1, 1'b1, 32'hF0);
    send(OP_SUB,  32'd0, 32'd1, 32'd0, 32'd0, 4'd5, 32'hFFFF_FFFF, 1'b0, 1'b0, 32'd0);
    send(OP_SLL,  32'd1, 32'h3F, 32'd0, 32'd0, 4'd6, 32'h8000_0000, 1'b0, 1'b0, 32'd0);
    send(OP_SRL,  32'h8000_0000, 32'd4, 32'd0, 32'd0, 4'd7, 32'h0800_0000, 1'b0, 1'b0, 32'd0);
    send(OP_XOR,  32'hF0F0, 32'hFF00, 32'd0, 32'd0, 4'd8, 32'h0FF0, 1'b0, 1'b0, 32'd0);
    send(OP_OR,   32'hF0F0, 32'hFF00, 32'd0, 32'd0, 4'd9, 32'hFFF0, 1'b0, 1'b0, 32'd0);
    send(OP_AND,  32'hF0F0, 32'hFF00, 32'd0, 32'd0, 4'd10, 32'hF000, 1'b0, 1'b0, 32'd0);
    send(OP_BEQ,  32'd5, 32'd5, 32'hFFFF_FFF8, 32'h10, 4'd11, 32'd1, 1'b1, 1'b1, 32'h8);
    send(OP_BGEU, 32'd1, 32'hFFFF_FFFF, 32'h200, 32'h4, 4'd12, 32'd0, 1'b1, 1'b0, 32'h204);
    send(OP_BGE,  32'd1, 32'hFFFF_FFFF, 32'h200, 32'h8, 4'd13, 32'd1, 1'b1, 1'b1, 32'h208);
    send(OP_BNE,  32'd7, 32'd7, 32'h300, 32'h4, 4'd14, 32'd0, 1'b1, 1'b0, 32'h304);
    send(OP_BLTU, 32'd1, 32'hFFFF_FFFF, 32'h0, 32'h4, 4'd15, 32'd1, 1'b1, 1'b1, 32'h4);
    send(5'd10,   32'd3, 32'd4, 32'h40, 32'h4, 4'd1, 32'd0, 1'b0, 1'b0, 32'd0);
    send(5'd22,   32'd3, 32'd4, 32'h40, 32'h4, 4'd2, 32'd0, 1'b0, 1'b0, 32'd0);
    drain();

    // Stall: four back-to-back ops with out_ready low for five cycles
    accept_cnt = 0;
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_add(i, 32'd10, i[3:0]);
      end
      begin
        snap_valid = 1'b0;
        for (int c = 0; c < 5; c++) begin
          @(negedge clk_in);
          if (snap_valid) chk("stall_value_stable", out_value, snap_value);
          if (out_valid && !snap_valid) begin
            snap_valid = 1'b1;
            snap_value = out_value;
          end
        end
        chk("stall_out_valid", {31'd0, out_valid}, 32'd1);
        chk("stall_accepts", accept_cnt, 32'd2);
        chk("stall_in_ready", {31'd0, in_ready}, 32'd0);
        @(posedge clk_in); #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Flush with two ops in flight and a same-cycle issue attempt
    out_ready = 1'b0;
    send_add(32'd100, 32'd1, 4'd5);
    send_add(32'd200, 32'd1, 4'd6);
    in_valid = 1'b1; in_op = OP_ADD; in_a = 32'd9; in_b = 32'd9; in_tag = 4'd9;
    flush_in = 1'b1;
    @(negedge clk_in);
    chk("flush_in_ready", {31'd0, in_ready}, 32'd0);
    @(posedge clk_in);
    exp_q.delete();
    #1;
    flush_in = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk_in);
    chk("flush_out_valid", {31'd0, out_valid}, 32'd0);
    @(posedge clk_in); #1;
    send_add(32'd40, 32'd2, 4'd7);
    @(negedge clk_in);
    chk("post_flush_lat1", {31'd0, out_valid}, 32'd0);
    @(negedge clk_in);
    chk("post_flush_lat2", {31'd0, out_valid}, 32'd1);
    @(posedge clk_in); #1;
    drain();

    // rdy_in low for three cycles mid-stream
    fork
      begin
        for (int i = 0; i < 4; i++) send_add(32'h1000 + i, 32'd1, 4'(i + 4));
      end
      begin
        repeat (2) @(posedge clk_in);
        #1 rdy_in = 1'b0;
        @(negedge clk_in);
        snap_valid = out_valid; snap_value = out_value; snap_tag = out_tag;
        chk("frz_in_ready0", {31'd0, in_ready}, 32'd0);
        for (int c = 0; c < 2; c++) begin
          @(negedge clk_in);
          chk("frz_valid", {31'd0, out_valid}, {31'd0, snap_valid});
          chk("frz_value", out_value, snap_value);
          chk("frz_tag", {28'd0, out_tag}, {28'd0, snap_tag});
          chk("frz_in_ready", {31'd0, in_ready}, 32'd0);
        end
        @(posedge clk_in); #1 rdy_in = 1'b1;
      end
    join
    drain();

    // Asynchronous reset mid-stream
    out_ready = 1'b0;
    send_add(32'd1, 32'd1, 4'd1);
    send_add(32'd2, 32'd2, 4'd2);
    @(negedge clk_in);
    chk("pre_rst_valid", {31'd0, out_valid}, 32'd1);
    #2 rst_in = 1'b0;
    #1;
    chk("async_rst_valid", {31'd0, out_valid}, 32'd0);
    chk("async_rst_value", out_value, 32'd0);
    exp_q.delete();
    @(posedge clk_in); #3 rst_in = 1'b1;
    out_ready = 1'b1;
    @(posedge clk_in); #1;
    send_add(32'd5, 32'd6, 4'd3);
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu_pipe.md
Name: alu_pipe

Overview:
- Parametrised, pipelined integer execution unit for the out-of-order RV32 core.
- Sits between the ALU reservation station (producer) and the CDB arbiter (consumer).
- Executes RV32I register/immediate arithmetic and conditional-branch resolution.
- Tags each result with its ROB index and adds configurable latency, valid/ready backpressure and mispredict flush.

Parameters:
- XLEN, 32: operand/result width; power of two, minimum 8.
- TAG_W, 4: ROB tag width.
- STAGES, 2: pipeline depth, 1 or 2. With 1, the result register is the only stage. With 2, an operand register precedes it.

Ports:
- clk_in  in  1  system clock.
- rst_in  in  1  reset; asynchronous, active-low.
- rdy_in  in  1  global ready; when low the whole unit freezes.
- flush_in  in  1  mispredict flush; discards all in-flight ops.
- in_valid  in  1  issue request from the reservation station.
- in_ready  out  1  unit can accept an op this cycle.
- in_op  in  5  operation code (alu_pkg encoding).
- in_a  in  XLEN  operand rs1.
- in_b  in  XLEN  operand rs2 or immediate.
- in_pc  in  XLEN  instruction PC (branches only).
- in_imm  in  XLEN  branch offset, sign-extended.
- in_tag  in  TAG_W  destination ROB tag.
- out_valid  out  1  result valid.
- out_ready  in  1  CDB accepts the result.
- out_tag  out  TAG_W  ROB tag of the result.
- out_value  out  XLEN  ALU result; for branches, 1 if taken else 0.
- out_is_branch  out  1  result belongs to a branch op.
- out_taken  out  1  branch condition true.
- out_target  out  XLEN  in_pc + in_imm, mod 2^XLEN.

Behaviour:
- Reset (rst_in=0, asynchronous):
  - All stage valid bits clear; out_valid=0.
  - out_tag, out_value, out_target, out_is_branch, out_taken all 0.
  - in_ready=1 once rst_in rises, provided rdy_in=1.
- Transfers:
  - Input transfer when in_valid & in_ready & rdy_in.
  - Output transfer when out_valid & out_ready & rdy_in.
- rdy_in=0:
  - No register changes, including flush.
  - in_ready forced to 0.
  - Outputs hold their values; a transfer never occurs.
- Ready chain, per stage k:
  - ready_k = !valid_k | ready_(k+1); the output stage uses out_ready.
  - in_ready = ready_0 & rdy_in & !flush_in.
  - Full throughput: one op per cycle while out_ready=1.
- Latency: an accepted op appears on out_valid exactly STAGES cycles later when unstalled.
- Stall (out_ready=0 with out_valid=1):
  - Output payload stable.
  - Upstream stages fill, then in_ready drops.
  - No op lost or duplicated.
- Flush (flush_in=1 & rdy_in=1):
  - All valid bits clear at the next edge.
  - The same-cycle input is not accepted (in_ready=0).
  - An output presented in the flush cycle is not considered transferred.
  - Flush has priority over every other update.
- Ops: ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND, BEQ, BNE, BLT, BGE, BLTU, BGEU.
- Arithmetic rules:
  - Add/sub wrap mod 2^XLEN.
  - Shift amount = in_b[log2(XLEN)-1:0]; SRA is arithmetic.
  - SLT/BLT/BGE compare signed; SLTU/BLTU/BGEU compare unsigned.
  - SLT/SLTU produce a zero-extended 0/1.
- Non-branch ops: out_is_branch=0, out_taken=0, out_target=0.
- Undefined opcode: out_value=0, treated as non-branch; not an error.
- Computation happens in the final stage combinationally from registered operands.
  - With STAGES=2, stage 0 registers in_* only.
  - Result registers update only on stage advance.

Decomposition:
- alu_pkg holds:
  - the 5-bit op encoding localparams (ADD=0 .. AND=9, BEQ=16 .. BGEU=21; bit4 = branch);
  - OP_W=5;
  - a helper function is_branch(op).
- One sub-module, alu_core: purely combinational, op/a/b/pc/imm -> value/taken/target.
- alu_pipe instantiates alu_core plus the valid/ready stage registers.

Test Plan:
- Reset then ADD a=0x7FFFFFFF, b=1, tag=3 -> after 2 cycles: out_valid=1, out_value=0x80000000, out_tag=3.
- SRA a=0x80000000, b=0x21 -> 0xC0000000 (shamt 1). SLTU a=1, b=0xFFFFFFFF -> 1. SLT with the same operands -> 0.
- BLT a=-1, b=0, pc=0x100, imm=0xFFFFFFF0 -> out_is_branch=1, out_taken=1, out_value=1, out_target=0xF0.
- Back-to-back 4 ops with out_ready=0 for 5 cycles:
  - out_value held stable;
  - in_ready=0 after 2 accepts;
  - then all 4 results emerge in order, tags 0..3.
- Flush with 2 ops in flight and in_valid=1 -> next cycle out_valid=0; the flush-cycle op is not accepted; a new op issued afterwards arrives with correct latency.
- Drop rdy_in for 3 cycles mid-stream -> no state change and no transfer; resume yields an identical result sequence. Assert rst_in mid-stream -> out_valid=0 immediately (asynchronous).
